// File: rtl/completion_broadcast_arbiter.sv
// Completion collection and broadcast arbiter.
// One holding slot per functional unit captures (result, tag) on done. A
// round-robin arbiter drains one slot per cycle onto the registered broadcast
// bus, and each FU is held off while its slot is occupied.

// Per-FU holding slot: capture on done, clear on grant, flag done-while-held.
module completion_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic                  grant,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic [TAG_WIDTH-1:0]  tag_q,
  output logic                  hold,
  output logic                  viol
);
  logic accept;

  // A slot being drained this cycle can take a new result on the same edge.
  always_comb begin
    hold   = valid & ~grant;
    accept = done & ~hold;
    viol   = done & hold;
  end

  // Slot state: reset empties it; a refill takes priority over the grant clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (accept) begin
      valid  <= 1'b1;
      data_q <= result;
      tag_q  <= tag;
    end else if (grant) begin
      valid  <= 1'b0;
    end
  end
endmodule

module completion_broadcast_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int EXEC_WIDTH = 4,
  localparam int NUM_FU    = 2**EXEC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  output logic [NUM_FU-1:0]            fu_hold,
  output logic                         dataAvailable,
  output logic [TAG_WIDTH-1:0]         destinationTag,
  output logic [DATA_WIDTH-1:0]        destinationData,
  output logic [EXEC_WIDTH-1:0]        destinationFU,
  output logic                         overflow_err
);
  logic [NUM_FU-1:0]                 slot_valid;
  logic [NUM_FU-1:0][DATA_WIDTH-1:0] slot_data;
  logic [NUM_FU-1:0][TAG_WIDTH-1:0]  slot_tag;
  logic [NUM_FU-1:0]                 slot_viol;
  logic [NUM_FU-1:0]                 gnt_oh;
  logic [EXEC_WIDTH-1:0]             rr_ptr;
  logic [EXEC_WIDTH-1:0]             gnt_idx;
  logic [EXEC_WIDTH-1:0]             scan_idx;
  logic                              gnt_vld;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    completion_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .done   (fu_done[i]),
      .result (fu_result[i*DATA_WIDTH +: DATA_WIDTH]),
      .tag    (fu_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .grant  (gnt_oh[i]),
      .valid  (slot_valid[i]),
      .data_q (slot_data[i]),
      .tag_q  (slot_tag[i]),
      .hold   (fu_hold[i]),
      .viol   (slot_viol[i])
    );
  end

  // Round-robin scan from rr_ptr; index arithmetic wraps at EXEC_WIDTH bits.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = rr_ptr + EXEC_WIDTH'(k);
      if (!gnt_vld && slot_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt_oh = gnt_vld ? (NUM_FU'(1) << gnt_idx) : '0;
  end

  // Broadcast register, pointer advance and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      dataAvailable   <= 1'b0;
      destinationTag  <= '0;
      destinationData <= '0;
      destinationFU   <= '0;
      overflow_err    <= 1'b0;
    end else begin
      dataAvailable <= gnt_vld;
      overflow_err  <= overflow_err | (|slot_viol);
      if (gnt_vld) begin
        destinationTag  <= slot_tag[gnt_idx];
        destinationData <= slot_data[gnt_idx];
        destinationFU   <= gnt_idx;
        rr_ptr          <= gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_completion_broadcast_arbiter.sv
// Bench for completion_broadcast_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a slot/queue reference model.
module tb_completion_broadcast_arbiter;
  localparam int DW = 32;
  localparam int TW = 7;
  localparam int EW = 4;
  localparam int NF = 16;

  logic                clk;
  logic                rst;
  logic [NF-1:0]       fu_done;
  logic [NF-1:0][DW-1:0] res_v;
  logic [NF-1:0][TW-1:0] tag_v;
  logic [NF-1:0]       fu_hold;
  logic                dataAvailable;
  logic [TW-1:0]       destinationTag;
  logic [DW-1:0]       destinationData;
  logic [EW-1:0]       destinationFU;
  logic                overflow_err;

  completion_broadcast_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .EXEC_WIDTH(EW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fu_done         (fu_done),
    .fu_result       (res_v),
    .fu_tag          (tag_v),
    .fu_hold         (fu_hold),
    .dataAvailable   (dataAvailable),
    .destinationTag  (destinationTag),
    .destinationData (destinationData),
    .destinationFU   (destinationFU),
    .overflow_err    (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy, held contents, next-in-line pointer, expected bus.
  bit          mv[NF];
  logic [DW-1:0] md[NF];
  logic [TW-1:0] mt[NF];
  int          rr;
  logic        e_da;
  logic [TW-1:0] e_tag;
  logic [DW-1:0] e_data;
  logic [EW-1:0] e_fu;
  logic        e_ov;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Next FU to be served: first occupied slot at or after rr, wrapping.
  function automatic int next_grant();
    for (int k = 0; k < NF; k++)
      if (mv[(rr + k) % NF]) return (rr + k) % NF;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin mv[i] = 0; md[i] = '0; mt[i] = '0; end
    rr = 0; e_da = 0; e_tag = '0; e_data = '0; e_fu = '0; e_ov = 0;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
    tag_v[i] = t;
    res_v[i] = v;
  endtask

  // One clock: compare current state, apply inputs, advance model, cross the edge.
  task automatic step(input logic [NF-1:0] d, input bit r);
    int g;
    logic [NF-1:0] eh;
    g = next_grant();
    for (int i = 0; i < NF; i++) eh[i] = mv[i] && (g != i);
    check("dataAvailable",   dataAvailable,   e_da);
    check("destinationTag",  destinationTag,  e_tag);
    check("destinationData", destinationData, e_data);
    check("destinationFU",   destinationFU,   e_fu);
    check("overflow_err",    overflow_err,    e_ov);
    check("fu_hold",         fu_hold,         eh);
    fu_done = d;
    rst     = r;
    if (r) model_reset();
    else begin
      for (int i = 0; i < NF; i++) if (d[i] && eh[i]) e_ov = 1;
      if (g >= 0) begin
        e_da = 1; e_tag = mt[g]; e_data = md[g]; e_fu = EW'(g);
        rr = (g + 1) % NF;
        mv[g] = 0;
      end else e_da = 0;
      for (int i = 0; i < NF; i++)
        if (d[i] && !eh[i]) begin mv[i] = 1; md[i] = res_v[i]; mt[i] = tag_v[i]; end
    end
    @(posedge clk);
    @(negedge clk);
    fu_done = '0;
    rst     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fu_done = '0; res_v = '0; tag_v = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_da",   dataAvailable, 1'b0);
    check("rst_hold", fu_hold, 16'h0);
    check("rst_ov",   overflow_err, 1'b0);

    // Single completion: done in cycle 1, broadcast two edges later.
    set_fu(9, 7'h15, 32'h0000_00AB);
    step(16'h0200, 0);
    step(16'h0000, 0);
    check("single_da",  dataAvailable, 1'b1);
    check("single_tag", destinationTag, 7'h15);
    check("single_dat", destinationData, 32'hAB);
    check("single_fu",  destinationFU, 4'd9);
    step(16'h0000, 0);
    check("single_da_off", dataAvailable, 1'b0);
    check("single_fu_hold", destinationFU, 4'd9);

    // Bring rr_ptr to 0 via a grant at FU 15 (pointer wrap).
    set_fu(15, 7'h0F, 32'hF0F0);
    step(16'h8000, 0);
    step(16'h0000, 0);
    step(16'h0000, 0);

    // Contention: FUs 0, 4, 8 together, served 0, 4, 8.
    set_fu(0, 7'h01, 32'h100); set_fu(4, 7'h04, 32'h400); set_fu(8, 7'h08, 32'h800);
    step(16'h0111, 0);
    check("cont_hold8_a", fu_hold[8], 1'b1);
    step(16'h0000, 0);
    check("cont_fu0", destinationFU, 4'd0);
    check("cont_hold8_b", fu_hold[8], 1'b1);
    step(16'h0000, 0);
    check("cont_fu4", destinationFU, 4'd4);
    check("cont_hold8_c", fu_hold[8], 1'b0);
    step(16'h0000, 0);
    check("cont_fu8", destinationFU, 4'd8);
    step(16'h0000, 0);

    // Fairness and wrap: rr_ptr reaches 15 with slots 15 and 2 occupied.
    set_fu(14, 7'h0E, 32'hE);
    step(16'h4000, 0);
    set_fu(15, 7'h2F, 32'h15F); set_fu(2, 7'h22, 32'h222);
    step(16'h8004, 0);
    check("wrap_fu14", destinationFU, 4'd14);
    step(16'h0000, 0);
    check("wrap_fu15", destinationFU, 4'd15);
    step(16'h0000, 0);
    check("wrap_fu2", destinationFU, 4'd2);
    step(16'h0000, 0);

    // Same-cycle refill of FU 1.
    set_fu(1, 7'h31, 32'h1111);
    step(16'h0002, 0);
    set_fu(1, 7'h32, 32'h2222);
    step(16'h0002, 0);
    check("refill_first", destinationData, 32'h1111);
    check("refill_ov",    overflow_err, 1'b0);
    step(16'h0000, 0);
    check("refill_second", destinationData, 32'h2222);
    check("refill_fu",     destinationFU, 4'd1);
    step(16'h0000, 0);

    // Violation: FU 3 done while held; the second result must be dropped.
    set_fu(2, 7'h42, 32'h4444); set_fu(3, 7'h43, 32'h11);
    step(16'h000C, 0);
    check("viol_hold3", fu_hold[3], 1'b1);
    set_fu(3, 7'h44, 32'h22);
    step(16'h0008, 0);
    check("viol_ov", overflow_err, 1'b1);
    step(16'h0000, 0);
    check("viol_data", destinationData, 32'h11);
    check("viol_fu",   destinationFU, 4'd3);
    step(16'h0000, 0);
    step(16'h0000, 0);
    check("viol_sticky", overflow_err, 1'b1);

    // Reset mid-operation with three slots occupied.
    set_fu(5, 7'h05, 32'h5); set_fu(6, 7'h06, 32'h6); set_fu(7, 7'h07, 32'h7);
    step(16'h00E0, 0);
    step(16'h0000, 1);
    check("mrst_da",   dataAvailable, 1'b0);
    check("mrst_hold", fu_hold, 16'h0);
    check("mrst_ov",   overflow_err, 1'b0);
    repeat (3) step(16'h0000, 0);

    // Random traffic with occasional violations and resets.
    for (int c = 0; c < 3000; c++) begin
      logic [NF-1:0] d;
      int g;
      g = next_grant();
      for (int i = 0; i < NF; i++) begin
        if (mv[i] && g != i) d[i] = ($urandom_range(63) == 0);
        else                 d[i] = ($urandom_range(3) == 0);
        res_v[i] = $urandom;
        tag_v[i] = TW'($urandom);
      end
      step(d, $urandom_range(399) == 0);
    end
    step(16'h0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
